// File: rtl/dram_cmd_responder_pkg.sv
// Shared types and timing defaults for the DDR4 command-bus responder.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: err_t, bank_state_t, dcmd_t, bus widths, timing defaults, decode_cmd().
package dram_cmd_responder_pkg;

   localparam int BANK_GROUP_BITS = 2;
   localparam int BANK_BITS       = 2;
   localparam int NUM_BG          = 2 ** BANK_GROUP_BITS;
   localparam int NUM_BA          = 2 ** BANK_BITS;
   localparam int NUM_BANKS       = NUM_BG * NUM_BA;
   localparam int ROW_W           = 15;
   localparam int COL_W           = 10;
   localparam int CNT_W           = 8;

   localparam int DEF_T_RCD   = 10;
   localparam int DEF_T_RAS   = 45;
   localparam int DEF_T_RP    = 10;
   localparam int DEF_T_RFC   = 172;
   localparam int DEF_T_RL    = 11;
   localparam int DEF_T_WL    = 11;
   localparam int DEF_T_BURST = 4;

   typedef enum logic [3:0] {
      ERR_NONE       = 4'd0,
      ERR_ILLEGAL    = 4'd1,
      ERR_BANK_BUSY  = 4'd2,
      ERR_ROW_CLOSED = 4'd3,
      ERR_TRCD       = 4'd4,
      ERR_TRAS       = 4'd5,
      ERR_TRP        = 4'd6,
      ERR_TRFC       = 4'd7,
      ERR_BURST      = 4'd8
   } err_t;

   typedef enum logic {
      B_IDLE   = 1'b0,
      B_ACTIVE = 1'b1
   } bank_state_t;

   typedef enum logic [3:0] {
      C_DESEL, C_ACT, C_MRS, C_REF, C_PRE, C_WR, C_RD, C_ZQ, C_NOP, C_ILLEGAL
   } dcmd_t;

   // c = {cs, act, ras, cas, we}. With act low the remaining bits carry row
   // address on a real bus, so they are ignored here.
   function automatic dcmd_t decode_cmd(input logic [4:0] c);
      dcmd_t d;
      d = C_ILLEGAL;
      if (c[4]) begin
         d = C_DESEL;
      end else if (!c[3]) begin
         d = C_ACT;
      end else begin
         case (c[2:0])
            3'b000:  d = C_MRS;
            3'b001:  d = C_REF;
            3'b010:  d = C_PRE;
            3'b011:  d = C_ILLEGAL;
            3'b100:  d = C_WR;
            3'b101:  d = C_RD;
            3'b110:  d = C_ZQ;
            default: d = C_NOP;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// One DRAM bank: open/closed state, open row, ACT age and precharge countdown.
// Latency: state updates on the edge that accepts ACT/PRE; status outputs are combinational from state.
// Backpressure: none; the parent only strobes do_act/do_pre when the matching *_ok is high.
// Ports: clk, rst (async high), do_act/do_pre strobes, act_row in;
//        active, act_ok, rw_ok, pre_ok, idle, row out.
module dram_bank_tracker
   import dram_cmd_responder_pkg::*;
#(
   parameter int T_RCD = DEF_T_RCD,
   parameter int T_RAS = DEF_T_RAS,
   parameter int T_RP  = DEF_T_RP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             do_act,
   input  logic             do_pre,
   input  logic [ROW_W-1:0] act_row,
   output logic             active,
   output logic             act_ok,
   output logic             rw_ok,
   output logic             pre_ok,
   output logic             idle,
   output logic [ROW_W-1:0] row
);

   bank_state_t state;
   logic [5:0]  age;
   logic [3:0]  pre_cnt;
   logic [6:0]  elapsed;
   logic        pre_busy;

   // A command sampled on an edge is judged against the counter value that
   // edge produces: age as if already incremented, pre_cnt as if already
   // decremented. That makes "expires on the same edge" count as expired.
   assign elapsed  = {1'b0, age} + 7'd1;
   assign pre_busy = (pre_cnt > 4'd1);

   assign active = (state == B_ACTIVE);
   assign act_ok = !active && !pre_busy;
   assign idle   = !active && !pre_busy;
   assign rw_ok  = active && (elapsed >= 7'(T_RCD));
   assign pre_ok = active && (elapsed >= 7'(T_RAS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= B_IDLE;
         row     <= '0;
         age     <= '0;
         pre_cnt <= '0;
      end else begin
         if (do_act) begin
            state <= B_ACTIVE;
            row   <= act_row;
            age   <= '0;
         end else if (do_pre) begin
            state <= B_IDLE;
         end else if (active && (age < 6'(T_RAS))) begin
            age <= age + 6'd1;
         end

         if (do_pre) begin
            pre_cnt <= 4'(T_RP);
         end else if (pre_cnt != 4'd0) begin
            pre_cnt <= pre_cnt - 4'd1;
         end
      end
   end

endmodule

// File: rtl/dram_cmd_responder.sv
// Device-side DDR4 command responder: decode, per-bank timing checks, refresh, rd/wr beat windows.
// Latency: errors one cycle after the command edge; first beat T_RL (rd) / T_WL (wr) cycles after acceptance.
// Backpressure: none; one command per cycle, illegal or mistimed commands are dropped with err_valid/err_code.
// Ports: CLK, RST (async high); cmd/bg/ba/row/col in; rd_valid, wr_ready, beat, burst_bank,
//        burst_row, burst_col, refreshing, err_valid, err_code out.
module dram_cmd_responder
   import dram_cmd_responder_pkg::*;
#(
   parameter int T_RCD   = DEF_T_RCD,
   parameter int T_RAS   = DEF_T_RAS,
   parameter int T_RP    = DEF_T_RP,
   parameter int T_RFC   = DEF_T_RFC,
   parameter int T_RL    = DEF_T_RL,
   parameter int T_WL    = DEF_T_WL,
   parameter int T_BURST = DEF_T_BURST
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       cmd,
   input  logic [1:0]       bg,
   input  logic [1:0]       ba,
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   output logic             rd_valid,
   output logic             wr_ready,
   output logic [1:0]       beat,
   output logic [3:0]       burst_bank,
   output logic [ROW_W-1:0] burst_row,
   output logic [COL_W-1:0] burst_col,
   output logic             refreshing,
   output logic             err_valid,
   output logic [3:0]       err_code
);

   dcmd_t      dcmd;
   logic [3:0] sel;

   logic [NUM_BANKS-1:0] bank_active;
   logic [NUM_BANKS-1:0] bank_act_ok;
   logic [NUM_BANKS-1:0] bank_rw_ok;
   logic [NUM_BANKS-1:0] bank_pre_ok;
   logic [NUM_BANKS-1:0] bank_idle;
   logic [ROW_W-1:0]     bank_row [NUM_BANKS];

   logic [CNT_W-1:0] rfc_cnt;
   logic [CNT_W-1:0] bst_cnt;
   logic             bst_is_rd;
   logic [3:0]       bst_bank;
   logic [ROW_W-1:0] bst_row;
   logic [COL_W-1:0] bst_col;
   err_t             err_q;

   logic rfc_busy, burst_pend, all_idle, in_window, bst_live;
   logic acc_act, acc_pre, acc_ref, acc_rd, acc_wr;
   err_t err_next;

   assign dcmd = decode_cmd(cmd);
   assign sel  = {bg, ba};

   // Same-edge expiry rule as the bank trackers: a count of 1 ends on this
   // edge, so it no longer blocks the command sampled here.
   assign rfc_busy   = (rfc_cnt > 8'd1);
   assign burst_pend = (bst_cnt > 8'd1);
   assign all_idle   = &bank_idle;

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      dram_bank_tracker #(
         .T_RCD (T_RCD),
         .T_RAS (T_RAS),
         .T_RP  (T_RP)
      ) u_trk (
         .clk     (CLK),
         .rst     (RST),
         .do_act  (acc_act && (sel == 4'(i))),
         .do_pre  (acc_pre && (sel == 4'(i))),
         .act_row (row),
         .active  (bank_active[i]),
         .act_ok  (bank_act_ok[i]),
         .rw_ok   (bank_rw_ok[i]),
         .pre_ok  (bank_pre_ok[i]),
         .idle    (bank_idle[i]),
         .row     (bank_row[i])
      );
   end

   // Exactly one outcome per command: either accepted or one error code.
   always_comb begin
      err_next = ERR_NONE;
      acc_act  = 1'b0;
      acc_pre  = 1'b0;
      acc_ref  = 1'b0;
      acc_rd   = 1'b0;
      acc_wr   = 1'b0;
      if (rfc_busy && (dcmd != C_DESEL) && (dcmd != C_NOP)) begin
         err_next = ERR_TRFC;
      end else begin
         case (dcmd)
            C_ACT: begin
               if (bank_act_ok[sel])      acc_act  = 1'b1;
               else if (bank_active[sel]) err_next = ERR_BANK_BUSY;
               else                       err_next = ERR_TRP;
            end
            C_RD, C_WR: begin
               if (!bank_active[sel])     err_next = ERR_ROW_CLOSED;
               else if (!bank_rw_ok[sel]) err_next = ERR_TRCD;
               else if (burst_pend)       err_next = ERR_BURST;
               else begin
                  acc_rd = (dcmd == C_RD);
                  acc_wr = (dcmd == C_WR);
               end
            end
            C_PRE: begin
               // Closing the row under an in-flight burst would orphan its data.
               if (burst_pend && (bst_bank == sel)) err_next = ERR_BANK_BUSY;
               else if (bank_pre_ok[sel])           acc_pre  = 1'b1;
               else if (bank_active[sel])           err_next = ERR_TRAS;
            end
            C_REF: begin
               if (all_idle && !burst_pend) acc_ref  = 1'b1;
               else                         err_next = ERR_BANK_BUSY;
            end
            C_MRS, C_ZQ: begin
               if (!all_idle) err_next = ERR_BANK_BUSY;
            end
            C_ILLEGAL: err_next = ERR_ILLEGAL;
            default: ;
         endcase
      end
   end

   // bst_cnt is loaded with latency + burst - 1 and counts to zero; the last
   // T_BURST counts form the beat window, so rd and wr share one counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rfc_cnt   <= '0;
         bst_cnt   <= '0;
         bst_is_rd <= 1'b0;
         bst_bank  <= '0;
         bst_row   <= '0;
         bst_col   <= '0;
         err_valid <= 1'b0;
         err_q     <= ERR_NONE;
      end else begin
         err_valid <= (err_next != ERR_NONE);
         err_q     <= err_next;

         if (acc_ref)               rfc_cnt <= 8'(T_RFC);
         else if (rfc_cnt != 8'd0)  rfc_cnt <= rfc_cnt - 8'd1;

         if (acc_rd || acc_wr) begin
            bst_cnt   <= acc_rd ? 8'(T_RL + T_BURST - 1) : 8'(T_WL + T_BURST - 1);
            bst_is_rd <= acc_rd;
            bst_bank  <= sel;
            bst_row   <= bank_row[sel];
            bst_col   <= col;
         end else if (bst_cnt != 8'd0) begin
            bst_cnt <= bst_cnt - 8'd1;
         end
      end
   end

   assign bst_live   = (bst_cnt != 8'd0);
   assign in_window  = bst_live && (bst_cnt <= 8'(T_BURST));
   assign rd_valid   = in_window && bst_is_rd;
   assign wr_ready   = in_window && !bst_is_rd;
   assign beat       = in_window ? 2'(8'(T_BURST) - bst_cnt) : 2'd0;
   assign burst_bank = bst_live ? bst_bank : 4'd0;
   assign burst_row  = bst_live ? bst_row : '0;
   assign burst_col  = bst_live ? bst_col : '0;
   assign refreshing = (rfc_cnt != 8'd0);
   assign err_code   = err_q;

endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Device-side responder for the controller's DDR4 command bus.
- Decodes the 5-bit {cs, act, ras, cas, we} command together with bank group, bank, row and column.
- Tracks per-bank open-row state and checks tRCD/tRAS/tRP/tRFC. Generates the read-data-valid and write-data-accept beat windows at tRL/tWL.
- Sits in the DRAM model / testbench side of the tensor-core memory path. Flags every protocol or timing violation with a coded error pulse.

Parameters:
- NUM_BG, 4 (2**BANK_GROUP_BITS), number of bank groups.
- NUM_BA, 4 (2**BANK_BITS), banks per group. Total banks NB = 16.
- T_RCD, tRCD (10), minimum cycles from ACT to READ/WRITE on the same bank.
- T_RAS, tRAS (45), minimum cycles from ACT to PRECHARGE.
- T_RP, tRP (10), precharge busy cycles.
- T_RFC, tRFC (172), refresh busy cycles.
- T_RL, tRL (11), cycles from READ acceptance to the first read beat.
- T_WL, tWL (11), cycles from WRITE acceptance to the first write beat.
- T_BURST, tBURST (4), beats per burst.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- cmd  in  5  {cs, act, ras, cas, we}, sampled every rising edge
- bg  in  2  bank group
- ba  in  2  bank
- row  in  15  row address (used on ACT)
- col  in  10  column address (used on READ/WRITE)
- rd_valid  out  1  read beat valid
- wr_ready  out  1  write beat accept window
- beat  out  2  beat index within the current burst
- burst_bank  out  4  {bg, ba} of the current burst
- burst_row  out  15  open row of the burst's bank
- burst_col  out  10  column of the burst
- refreshing  out  1  refresh in progress
- err_valid  out  1  one-cycle error pulse
- err_code  out  4  err_t code

Behaviour:
- Reset: all outputs are 0 and err_code is ERR_NONE. All banks are B_IDLE with counters 0. Any pending burst is cancelled immediately (asynchronous).
- Decode:
  - cs=1: DESEL.
  - cs=0, act=0: ACT.
  - cs=0, act=1, {ras,cas,we}: 000 MRS, 001 REF, 010 PRE, 100 WR, 101 RD, 110 ZQ, 111 NOP.
  - 011: ERR_ILLEGAL.
  - One command is accepted per cycle.
- Per-bank state: B_IDLE/B_ACTIVE, an open-row register, age counter, and precharge counter.
  - age counts cycles since ACT, saturating at T_RAS, 6 bits.
  - pre_cnt counts down from T_RP, 4 bits.
- ACT:
  - Legal if the bank is B_IDLE, pre_cnt==0 and not refreshing. Then the bank goes B_ACTIVE, the row is latched and age=0.
  - Bank B_ACTIVE: ERR_BANK_BUSY.
  - pre_cnt>0: ERR_TRP.
- RD/WR:
  - Legal if the bank is B_ACTIVE, age>=T_RCD and no burst is pending.
  - Bank B_IDLE: ERR_ROW_CLOSED.
  - age<T_RCD: ERR_TRCD.
  - Burst pending: ERR_BURST. "Pending" runs from acceptance through the last beat; there is no back-to-back pipelining.
- PRE:
  - Bank B_ACTIVE and age>=T_RAS: bank goes B_IDLE, pre_cnt=T_RP.
  - age<T_RAS: ERR_TRAS, bank stays open.
  - Bank already B_IDLE: no-op, no error.
- REF:
  - Legal only if every bank is B_IDLE with pre_cnt==0 and no burst is pending. Then refreshing=1 for T_RFC cycles.
  - Otherwise ERR_BANK_BUSY.
- During refresh, any command other than NOP/DESEL gives ERR_TRFC and is ignored.
- MRS/ZQ: accepted with no state change if all banks are idle, else ERR_BANK_BUSY.
- Rejected commands change no state.
- Errors are registered: err_valid pulses on cycle N+1 for a command at edge N. There is a single error per command.
- Burst timing for RD accepted at edge N:
  - rd_valid=1 on cycles N+T_RL through N+T_RL+T_BURST-1.
  - beat counts 0..T_BURST-1.
  - burst_* hold the tag from acceptance until the last beat.
- WR uses the same timing with wr_ready and T_WL.
- Implementation: one down-counter (CNT_W=8) plus a rd/wr flag.
- Simultaneous events: a PRE to bank X while a burst from bank X is pending is an ERR_BANK_BUSY. Counter expiry and a new command at the same edge see the expired value, i.e. the command is legal.

Decomposition:
- dram_pkg additions:
  - err_t enum (ERR_NONE, ERR_ILLEGAL, ERR_BANK_BUSY, ERR_ROW_CLOSED, ERR_TRCD, ERR_TRAS, ERR_TRP, ERR_TRFC, ERR_BURST).
  - bank_state_t (B_IDLE, B_ACTIVE).
  - decoded-command enum.
  - NUM_BANKS constant.
- Sub-module dram_bank_tracker, instantiated 16 times. It holds the state, row, age and pre_cnt for one bank, and exposes act_ok, rw_ok, pre_ok, idle and row.

Test Plan:
- ACT bank 5 row 0x1234 at cycle 0, RD col 0x20 at cycle 10 -> rd_valid cycles 21-24, beat 0,1,2,3, burst_row=0x1234, no err_valid.
- ACT at 0, RD at 9 -> err_valid at 10 with ERR_TRCD, no rd_valid. RD at 10 -> accepted.
- ACT at 0, PRE at 44 -> ERR_TRAS. PRE at 45 -> ok. ACT at 54 -> ERR_TRP. ACT at 55 -> ok.
- All banks idle, REF at 0 -> refreshing cycles 1-172. ACT at 100 -> ERR_TRFC. ACT at 173 -> ok.
- WR at N then RD at N+1 on an open bank -> second command ERR_BURST; wr_ready at N+11..N+14. Cmd 5'b01011 -> ERR_ILLEGAL.
- RST asserted mid-read (during beat 1) -> rd_valid falls without waiting for a clock. After release, RD to the previously open bank -> ERR_ROW_CLOSED.
